// File: rtl/vote_round_collector_if.sv
// Ballot-collector bus: round control and voter strobes in, captured ballot and status out.
// The master modport drives the round/vote side; the slave modport is the collector.
interface vote_round_collector_if;
  logic       round_start;
  logic       round_abort;
  logic [3:0] vote_valid;
  logic [3:0] vote_val;
  logic       out_ready;
  logic       out_valid;
  logic       A;
  logic       B;
  logic       C;
  logic       D;
  logic [3:0] cast_mask;
  logic       timed_out;
  logic       dup_vote;
  logic       busy;

  modport master (
    output round_start, round_abort, vote_valid, vote_val, out_ready,
    input  out_valid, A, B, C, D, cast_mask, timed_out, dup_vote, busy
  );

  modport slave (
    input  round_start, round_abort, vote_valid, vote_val, out_ready,
    output out_valid, A, B, C, D, cast_mask, timed_out, dup_vote, busy
  );
endinterface

// File: rtl/vote_round_collector.sv
// Collects one vote per voter (A..D) per round and holds the ballot until the majority stage takes it.
// Define VOTE_TIMEOUT_EN to close a round after TIMEOUT_CYCLES COLLECT cycles with missing votes as 0.
module vote_round_collector #(
  parameter int TIMEOUT_CYCLES = 100,
  parameter int CNT_W          = $clog2(TIMEOUT_CYCLES + 1)
) (
  input logic                   clk,
  input logic                   rst_n,
  vote_round_collector_if.slave bus
);

  typedef enum logic [1:0] {IDLE, COLLECT, HOLD} state_t;

  state_t     state;
  logic [3:0] votes;
  logic [3:0] mask;
  logic       out_valid_r;
  logic       timed_out_r;
  logic       dup_r;
  logic       busy_r;

  logic [3:0] new_cap;
  logic [3:0] dup_hit;
  logic [3:0] mask_next;
  logic [3:0] votes_next;

  if (TIMEOUT_CYCLES < 1 || CNT_W < $clog2(TIMEOUT_CYCLES + 1)) begin : g_bad_cfg
    $error("vote_round_collector: TIMEOUT_CYCLES must be >= 1 and CNT_W wide enough");
  end

  // First vote locks: only voters not yet in the mask are captured.
  for (genvar gi = 0; gi < 4; gi++) begin : g_voter
    assign new_cap[gi]    = bus.vote_valid[gi] & ~mask[gi];
    assign dup_hit[gi]    = bus.vote_valid[gi] & mask[gi];
    assign mask_next[gi]  = mask[gi] | new_cap[gi];
    assign votes_next[gi] = new_cap[gi] ? bus.vote_val[gi] : votes[gi];
  end

`ifdef VOTE_TIMEOUT_EN
  logic [CNT_W-1:0] timer;
  logic             timer_expired;
  assign timer_expired = (timer == CNT_W'(TIMEOUT_CYCLES - 1));
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      votes       <= 4'h0;
      mask        <= 4'h0;
      out_valid_r <= 1'b0;
      timed_out_r <= 1'b0;
      dup_r       <= 1'b0;
      busy_r      <= 1'b0;
`ifdef VOTE_TIMEOUT_EN
      timer       <= '0;
`endif
    end else begin
      dup_r <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.round_start) begin
            state       <= COLLECT;
            votes       <= 4'h0;
            mask        <= 4'h0;
            timed_out_r <= 1'b0;
            busy_r      <= 1'b1;
`ifdef VOTE_TIMEOUT_EN
            timer       <= '0;
`endif
          end
        end
        COLLECT: begin
          if (bus.round_abort) begin
            state  <= IDLE;
            votes  <= 4'h0;
            mask   <= 4'h0;
            busy_r <= 1'b0;
          end else begin
            votes <= votes_next;
            mask  <= mask_next;
            dup_r <= |dup_hit;
            // Full participation wins over a timeout on the same edge.
            if (mask_next == 4'hF) begin
              state       <= HOLD;
              out_valid_r <= 1'b1;
              timed_out_r <= 1'b0;
            end
`ifdef VOTE_TIMEOUT_EN
            else if (timer_expired) begin
              state       <= HOLD;
              out_valid_r <= 1'b1;
              timed_out_r <= 1'b1;
            end else begin
              timer <= timer + CNT_W'(1);
            end
`endif
          end
        end
        HOLD: begin
          if (bus.out_ready) begin
            state       <= IDLE;
            out_valid_r <= 1'b0;
            busy_r      <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.out_valid = out_valid_r;
  assign bus.A         = votes[3];
  assign bus.B         = votes[2];
  assign bus.C         = votes[1];
  assign bus.D         = votes[0];
  assign bus.cast_mask = mask;
  assign bus.timed_out = timed_out_r;
  assign bus.dup_vote  = dup_r;
  assign bus.busy      = busy_r;

endmodule

// File: tb/tb_vote_round_collector.sv
// Directed bench for vote_round_collector: a vector table for the round flow plus
// hand-written sequences for reset mid-round and timeout (or its absence).
module tb_vote_round_collector;
  localparam int TO = 8;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  vote_round_collector_if bus();

  vote_round_collector #(.TIMEOUT_CYCLES(TO)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Observed/expected word: {out_valid, A, B, C, D, cast_mask, timed_out, dup_vote, busy}
  typedef struct {
    logic       start;
    logic       abort;
    logic [3:0] vv;
    logic [3:0] val;
    logic       ready;
    logic [11:0] exp;
  } vec_t;

  vec_t tbl[23];
  int   n_checks = 0;
  int   n_errors = 0;

  function automatic logic [11:0] e(input logic ov, input logic [3:0] abcd, input logic [3:0] m,
                                    input logic to, input logic dup, input logic busy);
    return {ov, abcd, m, to, dup, busy};
  endfunction

  function automatic logic [11:0] obs();
    return {bus.out_valid, bus.A, bus.B, bus.C, bus.D, bus.cast_mask,
            bus.timed_out, bus.dup_vote, bus.busy};
  endfunction

  task automatic drive(input logic s, input logic a, input logic [3:0] vv,
                       input logic [3:0] val, input logic rdy);
    bus.round_start = s;
    bus.round_abort = a;
    bus.vote_valid  = vv;
    bus.vote_val    = val;
    bus.out_ready   = rdy;
  endtask

  task automatic drive_random();
    drive(1'($urandom), 1'($urandom), 4'($urandom), 4'($urandom), 1'($urandom));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [11:0] exp);
    logic [11:0] got;
    got = obs();
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got ov/abcd/mask/to/dup/busy=%03h expected %03h", name, got, exp);
    end else begin
      $display("ok   %s: %03h", name, got);
    end
  endtask

  initial begin
    // Full round with HOLD back-pressure, stray inputs in HOLD/IDLE
    tbl[0]  = '{1'b1, 1'b0, 4'h0, 4'h0, 1'b0, e(0, 4'h0, 4'h0, 0, 0, 1)};
    tbl[1]  = '{1'b0, 1'b0, 4'h8, 4'h8, 1'b0, e(0, 4'h8, 4'h8, 0, 0, 1)};
    tbl[2]  = '{1'b0, 1'b0, 4'h4, 4'h4, 1'b0, e(0, 4'hC, 4'hC, 0, 0, 1)};
    tbl[3]  = '{1'b0, 1'b0, 4'h2, 4'h0, 1'b0, e(0, 4'hC, 4'hE, 0, 0, 1)};
    tbl[4]  = '{1'b0, 1'b0, 4'h1, 4'h1, 1'b0, e(1, 4'hD, 4'hF, 0, 0, 1)};
    tbl[5]  = '{1'b1, 1'b1, 4'hF, 4'h0, 1'b0, e(1, 4'hD, 4'hF, 0, 0, 1)};
    tbl[6]  = '{1'b1, 1'b1, 4'hF, 4'h0, 1'b0, e(1, 4'hD, 4'hF, 0, 0, 1)};
    tbl[7]  = '{1'b1, 1'b0, 4'hF, 4'h0, 1'b0, e(1, 4'hD, 4'hF, 0, 0, 1)};
    tbl[8]  = '{1'b0, 1'b1, 4'hF, 4'h0, 1'b0, e(1, 4'hD, 4'hF, 0, 0, 1)};
    tbl[9]  = '{1'b0, 1'b0, 4'h0, 4'h0, 1'b1, e(0, 4'hD, 4'hF, 0, 0, 0)};
    tbl[10] = '{1'b0, 1'b1, 4'hF, 4'h0, 1'b0, e(0, 4'hD, 4'hF, 0, 0, 0)};
    // Duplicate vote alongside a fresh one, then abort
    tbl[11] = '{1'b1, 1'b0, 4'h0, 4'h0, 1'b0, e(0, 4'h0, 4'h0, 0, 0, 1)};
    tbl[12] = '{1'b0, 1'b0, 4'h8, 4'h8, 1'b0, e(0, 4'h8, 4'h8, 0, 0, 1)};
    tbl[13] = '{1'b0, 1'b0, 4'hC, 4'h0, 1'b0, e(0, 4'h8, 4'hC, 0, 1, 1)};
    tbl[14] = '{1'b0, 1'b0, 4'h0, 4'h0, 1'b0, e(0, 4'h8, 4'hC, 0, 0, 1)};
    tbl[15] = '{1'b0, 1'b1, 4'h0, 4'h0, 1'b0, e(0, 4'h0, 4'h0, 0, 0, 0)};
    // Abort with simultaneous votes, then a clean round completing in one cycle
    tbl[16] = '{1'b1, 1'b0, 4'h0, 4'h0, 1'b0, e(0, 4'h0, 4'h0, 0, 0, 1)};
    tbl[17] = '{1'b0, 1'b0, 4'hA, 4'hA, 1'b0, e(0, 4'hA, 4'hA, 0, 0, 1)};
    tbl[18] = '{1'b0, 1'b1, 4'h5, 4'h5, 1'b0, e(0, 4'h0, 4'h0, 0, 0, 0)};
    tbl[19] = '{1'b0, 1'b0, 4'h5, 4'h5, 1'b0, e(0, 4'h0, 4'h0, 0, 0, 0)};
    tbl[20] = '{1'b1, 1'b0, 4'h0, 4'h0, 1'b0, e(0, 4'h0, 4'h0, 0, 0, 1)};
    tbl[21] = '{1'b0, 1'b0, 4'hF, 4'h6, 1'b0, e(1, 4'h6, 4'hF, 0, 0, 1)};
    tbl[22] = '{1'b0, 1'b0, 4'hF, 4'h9, 1'b1, e(0, 4'h6, 4'hF, 0, 0, 0)};

    // Reset held for two cycles with random inputs
    rst_n = 1'b0;
    for (int i = 0; i < 2; i++) begin
      drive_random();
      tick();
      check($sformatf("reset_%0d", i), e(0, 4'h0, 4'h0, 0, 0, 0));
    end
    rst_n = 1'b1;
    drive(0, 0, 4'h0, 4'h0, 0);
    tick();
    check("idle_after_reset", e(0, 4'h0, 4'h0, 0, 0, 0));

    for (int i = 0; i < 23; i++) begin
      drive(tbl[i].start, tbl[i].abort, tbl[i].vv, tbl[i].val, tbl[i].ready);
      tick();
      check($sformatf("vec_%0d", i), tbl[i].exp);
    end

    // Reset mid-COLLECT
    drive(1, 0, 4'h0, 4'h0, 0); tick();
    drive(0, 0, 4'h8, 4'h8, 0); tick();
    check("pre_rst_collect", e(0, 4'h8, 4'h8, 0, 0, 1));
    rst_n = 1'b0; drive_random(); tick();
    check("rst_mid_collect", e(0, 4'h0, 4'h0, 0, 0, 0));
    rst_n = 1'b1;

    // Reset mid-HOLD, round_start in HOLD ignored
    drive(1, 0, 4'h0, 4'h0, 0); tick();
    drive(0, 0, 4'hF, 4'hF, 0); tick();
    check("hold_full", e(1, 4'hF, 4'hF, 0, 0, 1));
    drive(1, 0, 4'h0, 4'h0, 0); tick();
    check("hold_start_ignored", e(1, 4'hF, 4'hF, 0, 0, 1));
    rst_n = 1'b0; drive_random(); tick();
    check("rst_mid_hold", e(0, 4'h0, 4'h0, 0, 0, 0));
    rst_n = 1'b1;
    drive(0, 0, 4'h0, 4'h0, 0); tick();
    check("idle_after_hold_rst", e(0, 4'h0, 4'h0, 0, 0, 0));

`ifdef VOTE_TIMEOUT_EN
    // Timeout with only B and C voting: out_valid exactly TO cycles after entering COLLECT
    drive(1, 0, 4'h0, 4'h0, 0); tick();
    drive(0, 0, 4'h4, 4'h4, 0); tick();
    check("to_k1", e(0, 4'h4, 4'h4, 0, 0, 1));
    drive(0, 0, 4'h2, 4'h2, 0); tick();
    check("to_k2", e(0, 4'h6, 4'h6, 0, 0, 1));
    drive(0, 0, 4'h0, 4'h0, 0);
    for (int k = 3; k <= TO; k++) begin
      tick();
      check($sformatf("to_k%0d", k),
            (k == TO) ? e(1, 4'h6, 4'h6, 1, 0, 1) : e(0, 4'h6, 4'h6, 0, 0, 1));
    end
    drive(0, 0, 4'h0, 4'h0, 1); tick();
    check("to_handshake", e(0, 4'h6, 4'h6, 1, 0, 0));

    // D completes the ballot on the timeout edge: completion wins
    drive(1, 0, 4'h0, 4'h0, 0); tick();
    check("to2_open", e(0, 4'h0, 4'h0, 0, 0, 1));
    drive(0, 0, 4'h8, 4'h8, 0); tick();
    drive(0, 0, 4'h4, 4'h0, 0); tick();
    drive(0, 0, 4'h2, 4'h2, 0); tick();
    check("to2_k3", e(0, 4'hA, 4'hE, 0, 0, 1));
    drive(0, 0, 4'h0, 4'h0, 0);
    for (int k = 4; k < TO; k++) tick();
    check("to2_k7", e(0, 4'hA, 4'hE, 0, 0, 1));
    drive(0, 0, 4'h1, 4'h1, 0); tick();
    check("to2_complete_on_timeout", e(1, 4'hB, 4'hF, 0, 0, 1));
    drive(0, 0, 4'h0, 4'h0, 1); tick();
    check("to2_handshake", e(0, 4'hB, 4'hF, 0, 0, 0));
`else
    // Without the timeout feature an incomplete round stays open indefinitely
    drive(1, 0, 4'h0, 4'h0, 0); tick();
    drive(0, 0, 4'h6, 4'h6, 0); tick();
    drive(0, 0, 4'h0, 4'h0, 0);
    for (int k = 0; k < 3 * TO; k++) tick();
    check("no_timeout_long_wait", e(0, 4'h6, 4'h6, 0, 0, 1));
    drive(0, 1, 4'h0, 4'h0, 0); tick();
    check("no_timeout_abort", e(0, 4'h0, 4'h0, 0, 0, 0));
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
